// File: rtl/mem_responder_unit.sv
// mem_responder_unit: word-addressed RAM behind the MAR/MDR memory interface.
// Each accepted request goes through WAIT_STATES stall cycles and then one
// access cycle. done is raised and held until the requester drops both
// read and write.
//
// Parameters: DATA_W (word width), ADDR_W (address width), DEPTH (words),
//             WAIT_STATES (stall cycles, 0..15).
// Ports:
//   clk      - system clock, all state changes on posedge
//   clr      - synchronous active-low reset (array contents are kept)
//   read     - read request level, held until done
//   write    - write request level, held until done (read wins if both high)
//   addr     - word address, latched at accept
//   wr_data  - write data, latched at accept
//   mem_dout - registered read data to MDR
//   done     - registered request-complete flag, held until the request drops
//   busy     - registered, high from accept until the request is released
//   err      - registered address fault flag
// Optional feature macro: ADDR_RANGE_CHECK_EN
//   defined   - addresses >= DEPTH raise err with done. Reads return 0.
//               Writes are dropped.
//   undefined - err is tied low and the address wraps modulo DEPTH.
module mem_responder_unit #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] mem_dout,
  output logic              done,
  output logic              busy,
  output logic              err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_HOLD} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              op_rd;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  idx_c;
  logic              in_range_c;
  logic              wr_en_c;

  // Array index. This is the identity for in-range addresses and wraps the others.
  assign idx_c = IDX_W'(32'(addr_q) % DEPTH);

`ifdef ADDR_RANGE_CHECK_EN
  assign in_range_c = (32'(addr_q) < DEPTH);
`else
  assign in_range_c = 1'b1;
  assign err        = 1'b0;
`endif

  // clr is part of the enable, so a reset edge never commits a pending write.
  assign wr_en_c = clr && (state == S_ACCESS) && !op_rd && in_range_c;

  // Array storage. It has no reset, so contents survive clr.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[idx_c] <= wr_data_q;
    end
  end

  // Request sequencer and registered outputs
  always_ff @(posedge clk) begin
    if (!clr) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_rd     <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      mem_dout  <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
`ifdef ADDR_RANGE_CHECK_EN
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (read || write) begin
            addr_q    <= addr;
            wr_data_q <= wr_data;
            op_rd     <= read;
            busy      <= 1'b1;
            cnt       <= CNT_W'(WAIT_STATES);
            state     <= (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (op_rd) begin
            mem_dout <= in_range_c ? mem[idx_c] : '0;
          end
          done  <= 1'b1;
`ifdef ADDR_RANGE_CHECK_EN
          err   <= !in_range_c;
`endif
          state <= S_HOLD;
        end
        S_HOLD: begin
          // Release only after the requester drops both request lines.
          if (!read && !write) begin
            done  <= 1'b0;
            busy  <= 1'b0;
`ifdef ADDR_RANGE_CHECK_EN
            err   <= 1'b0;
`endif
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder_unit.sv
// Directed testbench for mem_responder_unit. Unit 0 uses the default
// parameters (WAIT_STATES=2, DEPTH=512). Unit 1 uses WAIT_STATES=0 and
// DEPTH=384 to cover zero-wait latency and out-of-range addresses.
module tb_mem_responder_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b0;

  logic        rd0 = 1'b0, wr0 = 1'b0;
  logic [8:0]  a0  = '0;
  logic [31:0] wd0 = '0;
  logic [31:0] dout0;
  logic        done0, busy0, err0;

  logic        rd1 = 1'b0, wr1 = 1'b0;
  logic [8:0]  a1  = '0;
  logic [31:0] wd1 = '0;
  logic [31:0] dout1;
  logic        done1, busy1, err1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder_unit #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .WAIT_STATES(2)) u0 (
    .clk(clk), .clr(clr), .read(rd0), .write(wr0), .addr(a0), .wr_data(wd0),
    .mem_dout(dout0), .done(done0), .busy(busy0), .err(err0)
  );

  mem_responder_unit #(.DATA_W(32), .ADDR_W(9), .DEPTH(384), .WAIT_STATES(0)) u1 (
    .clk(clk), .clr(clr), .read(rd1), .write(wr1), .addr(a1), .wr_data(wd1),
    .mem_dout(dout1), .done(done1), .busy(busy1), .err(err1)
  );

  task automatic drive(input bit u, input logic rd, input logic wr,
                       input logic [8:0] a, input logic [31:0] d);
    if (!u) begin rd0 = rd; wr0 = wr; a0 = a; wd0 = d; end
    else    begin rd1 = rd; wr1 = wr; a1 = a; wd1 = d; end
  endtask

  function automatic logic get_done(input bit u);
    return u ? done1 : done0;
  endfunction

  // Issues a request and returns the number of posedges from accept until done is seen (-1 on timeout).
  task automatic do_req(input bit u, input logic rd, input logic wr,
                        input logic [8:0] a, input logic [31:0] d, output int lat);
    @(negedge clk);
    drive(u, rd, wr, a, d);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (get_done(u)) begin
        lat = i;
        break;
      end
    end
  endtask

  // Drops the request and waits one edge so the unit can return to IDLE.
  task automatic release_req(input bit u);
    @(negedge clk);
    if (!u) begin rd0 = 1'b0; wr0 = 1'b0; end
    else    begin rd1 = 1'b0; wr1 = 1'b0; end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    checks++; if (dout0 !== 32'h0) begin errors++; $display("FAIL reset_dout got %h exp 0", dout0); end
    checks++; if (done0 !== 1'b0)  begin errors++; $display("FAIL reset_done got %b exp 0", done0); end
    checks++; if (busy0 !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b exp 0", busy0); end
    checks++; if (err0  !== 1'b0)  begin errors++; $display("FAIL reset_err got %b exp 0", err0); end
    checks++; if (done1 !== 1'b0 || busy1 !== 1'b0 || dout1 !== 32'h0)
      begin errors++; $display("FAIL reset_u1 got done=%b busy=%b dout=%h exp 0", done1, busy1, dout1); end
  endtask

  task automatic test_write();
    logic [3:0] exp_done;
    exp_done = 4'b1000;  // done is low after edges N, N+1 and N+2, high after N+3
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 9'd5, 32'h2);
    for (int e = 0; e < 4; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 0) begin
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL write_busy got %b exp 1", busy0); end
        // Inputs that change after accept must not affect the request.
        a0 = 9'd9; wd0 = 32'hFFFF_FFFF;
      end
      checks++;
      if (done0 !== exp_done[e]) begin
        errors++; $display("FAIL write_done_edge%0d got %b exp %b", e, done0, exp_done[e]);
      end
    end
    for (int h = 0; h < 2; h++) begin
      @(posedge clk);
      @(negedge clk);
      checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL write_hold%0d got %b exp 1", h, done0); end
    end
    wr0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (done0 !== 1'b0 || busy0 !== 1'b0)
      begin errors++; $display("FAIL write_release got done=%b busy=%b exp 0 0", done0, busy0); end
  endtask

  task automatic test_read();
    int lat;
    do_req(0, 1'b1, 1'b0, 9'd5, 32'h0, lat);
    checks++; if (lat !== 4)         begin errors++; $display("FAIL read_latency got %0d exp 4", lat); end
    checks++; if (dout0 !== 32'h2)   begin errors++; $display("FAIL read5 got %h exp 2", dout0); end
    a0 = 9'd6;
    repeat (2) @(negedge clk);
    checks++; if (dout0 !== 32'h2 || done0 !== 1'b1)
      begin errors++; $display("FAIL read_stable got dout=%h done=%b exp 2 1", dout0, done0); end
    release_req(0);
    do_req(0, 1'b0, 1'b1, 9'd6, 32'h3, lat);
    release_req(0);
    do_req(0, 1'b1, 1'b0, 9'd6, 32'h0, lat);
    checks++; if (dout0 !== 32'h3)   begin errors++; $display("FAIL read6 got %h exp 3", dout0); end
    release_req(0);
  endtask

  task automatic test_both();
    int lat;
    do_req(0, 1'b1, 1'b1, 9'd5, 32'hDEAD_BEEF, lat);
    checks++; if (dout0 !== 32'h2)   begin errors++; $display("FAIL both_dout got %h exp 2", dout0); end
    release_req(0);
    do_req(0, 1'b1, 1'b0, 9'd5, 32'h0, lat);
    checks++; if (dout0 !== 32'h2)   begin errors++; $display("FAIL both_mem5 got %h exp 2", dout0); end
    release_req(0);
  endtask

  task automatic test_clr_abort();
    int lat;
    do_req(0, 1'b0, 1'b1, 9'd7, 32'h77, lat);
    release_req(0);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 9'd7, 32'hA5);
    @(posedge clk);            // accept edge
    @(negedge clk);
    clr = 1'b0;                // reset lands while the request is in WAIT
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy0 !== 1'b0 || done0 !== 1'b0)
      begin errors++; $display("FAIL abort_state got busy=%b done=%b exp 0 0", busy0, done0); end
    clr = 1'b1;
    wr0 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%b exp 0", busy0); end
    do_req(0, 1'b1, 1'b0, 9'd7, 32'h0, lat);
    checks++; if (dout0 !== 32'h77)  begin errors++; $display("FAIL abort_mem7 got %h exp 77", dout0); end
    release_req(0);
  endtask

  task automatic test_zero_wait_range();
    int lat;
    logic [31:0] exp_rd, exp_16;
    logic        exp_err;
`ifdef ADDR_RANGE_CHECK_EN
    exp_err = 1'b1; exp_rd = 32'h0;    exp_16 = 32'h1616;
`else
    exp_err = 1'b0; exp_rd = 32'h1616; exp_16 = 32'hBEEF;
`endif
    do_req(1, 1'b0, 1'b1, 9'd16, 32'h1616, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL zw_latency got %0d exp 2", lat); end
    release_req(1);
    do_req(1, 1'b1, 1'b0, 9'd400, 32'h0, lat);
    checks++; if (err1 !== exp_err) begin errors++; $display("FAIL range_err got %b exp %b", err1, exp_err); end
    checks++; if (dout1 !== exp_rd) begin errors++; $display("FAIL range_dout got %h exp %h", dout1, exp_rd); end
    release_req(1);
    checks++; if (err1 !== 1'b0 || done1 !== 1'b0)
      begin errors++; $display("FAIL range_release got err=%b done=%b exp 0 0", err1, done1); end
    do_req(1, 1'b0, 1'b1, 9'd400, 32'hBEEF, lat);
    release_req(1);
    do_req(1, 1'b1, 1'b0, 9'd16, 32'h0, lat);
    checks++; if (dout1 !== exp_16) begin errors++; $display("FAIL range_mem16 got %h exp %h", dout1, exp_16); end
    release_req(1);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_both();
    test_clr_abort();
    test_zero_wait_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
